// File: rtl/mu0_run_ctrl.sv
// Run/step controller for the MU0 CPU: generates the CPU clock in fast, slow
// or manual modes and stops on halt, breakpoint or cycle limit.
module mu0_run_ctrl #(
  parameter int unsigned SLOW_DIV = 6318000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       clk_mode,
  input  logic             start,
  input  logic             step_req,
  input  logic             done,
  input  logic [15:0]      pc,
  input  logic             bp_en,
  input  logic [15:0]      bp_addr,
  input  logic [CNT_W-1:0] cyc_limit,
  output logic             cpu_clk,
  output logic             enable,
  output logic [1:0]       halt_reason,
  output logic [CNT_W-1:0] cyc_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALT} state_t;

  localparam logic [3:0] MODE_FAST   = 4'd1;
  localparam logic [3:0] MODE_SLOW   = 4'd2;
  localparam logic [3:0] MODE_MAN_ON = 4'd4;

  localparam logic [1:0] HR_NONE  = 2'd0;
  localparam logic [1:0] HR_DONE  = 2'd1;
  localparam logic [1:0] HR_BP    = 2'd2;
  localparam logic [1:0] HR_LIMIT = 2'd3;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(SLOW_DIV);

  state_t           state_q, state_d;
  logic             cpu_clk_q, cpu_clk_d;
  logic             enable_q, enable_d;
  logic [1:0]       halt_reason_q, halt_reason_d;
  logic [CNT_W-1:0] cyc_count_q, cyc_count_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             start_q, start_d;

  logic start_evt, slow, div_wrap, clk_nxt, rise, bp_hit, limit_hit, step_tick;

  always_comb begin
    state_d       = state_q;
    cpu_clk_d     = cpu_clk_q;
    halt_reason_d = halt_reason_q;
    cyc_count_d   = cyc_count_q;
    div_d         = '0;
    start_d       = start;

    start_evt = (start != start_q);
    slow      = (clk_mode == MODE_SLOW);
    div_wrap  = (div_q == DIV_N);

    case (clk_mode)
      MODE_FAST:   clk_nxt = ~cpu_clk_q;
      MODE_SLOW:   clk_nxt = div_wrap ? ~cpu_clk_q : cpu_clk_q;
      MODE_MAN_ON: clk_nxt = 1'b1;
      default:     clk_nxt = 1'b0;
    endcase
    rise      = ~cpu_clk_q & clk_nxt;
    bp_hit    = rise && bp_en && (pc == bp_addr) && (cyc_count_q != '0);
    limit_hit = (cyc_limit != '0) && (cyc_count_q == cyc_limit) && !cpu_clk_q;
    step_tick = slow ? div_wrap : 1'b1;

    case (state_q)
      S_RUN, S_STEP: begin
        if (slow) div_d = div_wrap ? '0 : div_q + ONE;
        if (done) begin
          state_d       = S_HALT;
          halt_reason_d = HR_DONE;
          cpu_clk_d     = 1'b0;
        end else if (state_q == S_RUN) begin
          // A breakpoint suppresses the rise so the CPU never executes that pc.
          if (bp_hit) begin
            state_d       = S_HALT;
            halt_reason_d = HR_BP;
            cpu_clk_d     = 1'b0;
          end else if (limit_hit) begin
            state_d       = S_HALT;
            halt_reason_d = HR_LIMIT;
            cpu_clk_d     = 1'b0;
          end else begin
            cpu_clk_d = clk_nxt;
            if (rise) cyc_count_d = cyc_count_q + ONE;
          end
        end else if (step_tick) begin
          if (!cpu_clk_q) begin
            cpu_clk_d   = 1'b1;
            cyc_count_d = cyc_count_q + ONE;
          end else begin
            cpu_clk_d     = 1'b0;
            state_d       = S_HALT;
            halt_reason_d = HR_NONE;
          end
        end
      end
      default: begin
        cpu_clk_d = 1'b0;
        if (start_evt) begin
          state_d       = S_RUN;
          cyc_count_d   = '0;
          halt_reason_d = HR_NONE;
        end else if (step_req) begin
          state_d = S_STEP;
        end
      end
    endcase

    enable_d = (state_d == S_RUN) || (state_d == S_STEP);
    if (!enable_d || (state_q != state_d)) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cpu_clk_q     <= 1'b0;
      enable_q      <= 1'b0;
      halt_reason_q <= HR_NONE;
      cyc_count_q   <= '0;
      div_q         <= '0;
      start_q       <= start;
    end else begin
      state_q       <= state_d;
      cpu_clk_q     <= cpu_clk_d;
      enable_q      <= enable_d;
      halt_reason_q <= halt_reason_d;
      cyc_count_q   <= cyc_count_d;
      div_q         <= div_d;
      start_q       <= start_d;
    end
  end

  assign cpu_clk     = cpu_clk_q;
  assign enable      = enable_q;
  assign halt_reason = halt_reason_q;
  assign cyc_count   = cyc_count_q;

endmodule
